ft600_emu: RTL

- Synthesizable device-side model of the FT600 245-synchronous FIFO bus: the chip end of the interface that the FPGA-side FT600 master FSM drives.
- Holds two word FIFOs:
  - to-FPGA FIFO (T2F): filled from a host-side stream port and drained over the bus with oe_n/rd_n.
  - from-FPGA FIFO (F2T): filled over the bus with wr_n and drained to a host-side stream port.
- Used for on-chip loopback and in benches as the FT600 stand-in.

---
 rtl/ft600_emu.sv | 103 ++++++++++
 1 files changed

// File: rtl/ft600_emu.sv
// Device-side FT600 245-sync FIFO bus model with T2F/F2T word FIFOs.
// Optional LFSR flag stalling is enabled with `define FT600_EMU_STALL_EN.
module ft600_emu #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int DEPTH_LOG2    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     rxf_n,
    output logic                     txe_n,
    input  logic                     oe_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    inout  wire  [FT_DATA_WIDTH-1:0] ft_data,
    inout  wire  [3:0]               ft_be,
    input  logic [FT_DATA_WIDTH-1:0] host_wdata,
    input  logic                     host_wvalid,
    output logic                     host_wready,
    output logic [FT_DATA_WIDTH-1:0] host_rdata,
    output logic                     host_rvalid,
    input  logic                     host_rready,
    output logic                     err_rd_empty,
    output logic                     err_wr_full,
    output logic                     err_protocol
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [FT_DATA_WIDTH-1:0] t2f_mem [DEPTH];
    logic [FT_DATA_WIDTH-1:0] f2t_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] t2f_wptr, t2f_rptr, f2t_wptr, f2t_rptr;
    logic [CW-1:0] t2f_count, f2t_count, t2f_count_next, f2t_count_next;
    logic t2f_push, t2f_pop, f2t_push, f2t_pop;
    logic stall;

`ifdef FT600_EMU_STALL_EN
    logic [15:0] lfsr, lfsr_next;
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall = (lfsr_next[3:0] == 4'h0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= lfsr_next;
    end
`else
    assign stall = 1'b0;
`endif

    // Handshakes use the registered flags, so a stalled or empty/full
    // flag blocks the transfer even if occupancy would allow it.
    always_comb begin
        t2f_push = host_wvalid & host_wready;
        t2f_pop  = ~rd_n & ~oe_n & ~rxf_n;
        f2t_push = ~wr_n & oe_n & ~txe_n;
        f2t_pop  = host_rvalid & host_rready;
        t2f_count_next = t2f_count + CW'(t2f_push) - CW'(t2f_pop);
        f2t_count_next = f2t_count + CW'(f2t_push) - CW'(f2t_pop);
    end

    assign host_rvalid = (f2t_count != '0);
    assign host_rdata  = host_rvalid ? f2t_mem[f2t_rptr] : '0;
    assign ft_data = (!oe_n && !reset) ? t2f_mem[t2f_rptr] : {FT_DATA_WIDTH{1'bz}};
    assign ft_be   = (!oe_n && !reset) ? 4'b1111 : 4'bzzzz;

    always_ff @(posedge clk) begin
        if (t2f_push) t2f_mem[t2f_wptr] <= host_wdata;
        if (f2t_push) f2t_mem[f2t_wptr] <= ft_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t2f_wptr     <= '0;
            t2f_rptr     <= '0;
            f2t_wptr     <= '0;
            f2t_rptr     <= '0;
            t2f_count    <= '0;
            f2t_count    <= '0;
            rxf_n        <= 1'b1;
            txe_n        <= 1'b1;
            host_wready  <= 1'b0;
            err_rd_empty <= 1'b0;
            err_wr_full  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            if (t2f_push) t2f_wptr <= t2f_wptr + PTR_ONE;
            if (t2f_pop)  t2f_rptr <= t2f_rptr + PTR_ONE;
            if (f2t_push) f2t_wptr <= f2t_wptr + PTR_ONE;
            if (f2t_pop)  f2t_rptr <= f2t_rptr + PTR_ONE;
            t2f_count   <= t2f_count_next;
            f2t_count   <= f2t_count_next;
            rxf_n       <= (t2f_count_next == '0) | stall;
            txe_n       <= (f2t_count_next == FULL) | stall;
            host_wready <= (t2f_count_next != FULL);
            if (!rd_n && rxf_n)
                err_rd_empty <= 1'b1;
            if (!wr_n && txe_n)
                err_wr_full <= 1'b1;
            if ((!wr_n && !oe_n) || (!rd_n && oe_n))
                err_protocol <= 1'b1;
        end
    end
endmodule
